// File: rtl/rename_regfile_pkg.sv
// rf_pkg: shared definitions for the rename register file.
//   TAG_NONE      tag value meaning "operand value is ready"
//   RF_*          default widths and channel count
//   rf_operand_t  value/tag pair returned for one source operand
package rf_pkg;
   localparam int unsigned RF_REG_COUNT = 32;
   localparam int unsigned RF_DATA_W    = 32;
   localparam int unsigned RF_TAG_W     = 32;
   localparam int unsigned RF_ISSUE_W   = 2;
   localparam int unsigned RF_IDX_W     = $clog2(RF_REG_COUNT);

   localparam logic [RF_TAG_W-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic [RF_DATA_W-1:0] v;
      logic [RF_TAG_W-1:0]  q;
   } rf_operand_t;
endpackage

// File: rtl/rename_regfile_if.sv
// rename_regfile_if: dispatch, commit and result bundle between the
// decoder/ROB side (master) and the rename register file (slave).
//   flush_i/stall_i        ROB control
//   commit_*               one retiring result per cycle
//   disp_*                 packed per-channel dispatch fields, slice k = channel k
//   disp_ready_o           dispatch acceptance
//   out_*                  registered per-channel operand value/tag pairs
interface rename_regfile_if #(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 32,
   parameter int unsigned ISSUE_W   = 2,
   parameter int unsigned IDX_W     = $clog2(REG_COUNT)
);
   logic                       flush_i;
   logic                       stall_i;
   logic                       commit_valid_i;
   logic [IDX_W-1:0]           commit_rd_i;
   logic [TAG_W-1:0]           commit_tag_i;
   logic [DATA_W-1:0]          commit_data_i;
   logic [ISSUE_W-1:0]         disp_valid_i;
   logic [ISSUE_W*IDX_W-1:0]   disp_rd_i;
   logic [ISSUE_W*IDX_W-1:0]   disp_rs1_i;
   logic [ISSUE_W*IDX_W-1:0]   disp_rs2_i;
   logic [ISSUE_W*TAG_W-1:0]   disp_tag_i;
   logic                       disp_ready_o;
   logic [ISSUE_W-1:0]         out_valid_o;
   logic [ISSUE_W*DATA_W-1:0]  out_v1_o;
   logic [ISSUE_W*DATA_W-1:0]  out_v2_o;
   logic [ISSUE_W*TAG_W-1:0]   out_q1_o;
   logic [ISSUE_W*TAG_W-1:0]   out_q2_o;
   logic [ISSUE_W*IDX_W-1:0]   out_rd_o;
   logic [ISSUE_W*TAG_W-1:0]   out_tag_o;

   modport master (
      output flush_i, stall_i, commit_valid_i, commit_rd_i, commit_tag_i, commit_data_i,
      output disp_valid_i, disp_rd_i, disp_rs1_i, disp_rs2_i, disp_tag_i,
      input  disp_ready_o, out_valid_o, out_v1_o, out_v2_o, out_q1_o, out_q2_o,
      input  out_rd_o, out_tag_o
   );

   modport slave (
      input  flush_i, stall_i, commit_valid_i, commit_rd_i, commit_tag_i, commit_data_i,
      input  disp_valid_i, disp_rd_i, disp_rs1_i, disp_rs2_i, disp_tag_i,
      output disp_ready_o, out_valid_o, out_v1_o, out_v2_o, out_q1_o, out_q2_o,
      output out_rd_o, out_tag_o
   );
endinterface

// File: rtl/rename_regfile_operand_sel.sv
// rf_operand_sel: priority mux for one source operand.
//   fwd_hit_i/fwd_tag_i   older channel in the same bundle renames this register
//   byp_hit_i/byp_data_i  same-cycle commit retires the current producer
//   arr_v_i/arr_q_i       register array contents
//   v_o/q_o               selected value/tag
module rf_operand_sel
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 32
) (
   input  logic              fwd_hit_i,
   input  logic [TAG_W-1:0]  fwd_tag_i,
   input  logic              byp_hit_i,
   input  logic [DATA_W-1:0] byp_data_i,
   input  logic [DATA_W-1:0] arr_v_i,
   input  logic [TAG_W-1:0]  arr_q_i,
   output logic [DATA_W-1:0] v_o,
   output logic [TAG_W-1:0]  q_o
);
   always_comb begin
      v_o = arr_v_i;
      q_o = arr_q_i;
      if (fwd_hit_i) begin
         // value is produced by an instruction not yet executed
         v_o = '0;
         q_o = fwd_tag_i;
      end else if (byp_hit_i) begin
         v_o = byp_data_i;
         q_o = TAG_W'(TAG_NONE);
      end
   end
endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with rename tags.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        rename_regfile_if.slave (dispatch, commit, registered results)
// Optional feature macro: RF_COMMIT_BYPASS_EN enables same-cycle commit
// forwarding into operand reads and commit snooping of held outputs.
module rename_regfile
   import rf_pkg::*;
#(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 32,
   parameter int unsigned ISSUE_W   = 2,
   parameter int unsigned IDX_W     = $clog2(REG_COUNT)
) (
   input logic            clk,
   input logic            rst,
   rename_regfile_if.slave bus
);
   logic [DATA_W-1:0] rf_value_q [REG_COUNT];
   logic [DATA_W-1:0] rf_value_d [REG_COUNT];
   logic [TAG_W-1:0]  rf_tag_q   [REG_COUNT];
   logic [TAG_W-1:0]  rf_tag_d   [REG_COUNT];

   logic [ISSUE_W-1:0] out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_v_q   [ISSUE_W][2];
   logic [DATA_W-1:0]  out_v_d   [ISSUE_W][2];
   logic [TAG_W-1:0]   out_q_q   [ISSUE_W][2];
   logic [TAG_W-1:0]   out_q_d   [ISSUE_W][2];
   logic [IDX_W-1:0]   out_rd_q  [ISSUE_W];
   logic [IDX_W-1:0]   out_rd_d  [ISSUE_W];
   logic [TAG_W-1:0]   out_tag_q [ISSUE_W];
   logic [TAG_W-1:0]   out_tag_d [ISSUE_W];

   logic               ready;
   logic [ISSUE_W-1:0] accept;
   logic [IDX_W-1:0]   disp_rd  [ISSUE_W];
   logic [IDX_W-1:0]   disp_rs  [ISSUE_W][2];
   logic [TAG_W-1:0]   disp_tag [ISSUE_W];

   logic               fwd_hit [ISSUE_W][2];
   logic [TAG_W-1:0]   fwd_tag [ISSUE_W][2];
   logic               byp_hit [ISSUE_W][2];
   logic [DATA_W-1:0]  arr_v   [ISSUE_W][2];
   logic [TAG_W-1:0]   arr_q   [ISSUE_W][2];
   logic [DATA_W-1:0]  sel_v   [ISSUE_W][2];
   logic [TAG_W-1:0]   sel_q   [ISSUE_W][2];

   assign ready            = !bus.stall_i && !bus.flush_i;
   assign accept           = bus.disp_valid_i & {ISSUE_W{ready}};
   assign bus.disp_ready_o = ready;

   always_comb begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         disp_rd[k]    = bus.disp_rd_i[k*IDX_W +: IDX_W];
         disp_rs[k][0] = bus.disp_rs1_i[k*IDX_W +: IDX_W];
         disp_rs[k][1] = bus.disp_rs2_i[k*IDX_W +: IDX_W];
         disp_tag[k]   = bus.disp_tag_i[k*TAG_W +: TAG_W];
      end
   end

   // Operand sources. Ascending j leaves the youngest older writer in place.
   always_comb begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         for (int unsigned op = 0; op < 2; op++) begin
            fwd_hit[k][op] = 1'b0;
            fwd_tag[k][op] = '0;
            for (int unsigned j = 0; j < k; j++) begin
               if (accept[j] && disp_rd[j] == disp_rs[k][op] && disp_rs[k][op] != '0) begin
                  fwd_hit[k][op] = 1'b1;
                  fwd_tag[k][op] = disp_tag[j];
               end
            end
            arr_v[k][op]   = rf_value_q[disp_rs[k][op]];
            arr_q[k][op]   = rf_tag_q[disp_rs[k][op]];
            byp_hit[k][op] = 1'b0;
`ifdef RF_COMMIT_BYPASS_EN
            byp_hit[k][op] = bus.commit_valid_i && bus.commit_rd_i == disp_rs[k][op] &&
                             disp_rs[k][op] != '0 &&
                             rf_tag_q[disp_rs[k][op]] == bus.commit_tag_i;
`endif
         end
      end
   end

   for (genvar k = 0; k < ISSUE_W; k++) begin : g_chan
      for (genvar op = 0; op < 2; op++) begin : g_op
         rf_operand_sel #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
         ) u_sel (
            .fwd_hit_i  (fwd_hit[k][op]),
            .fwd_tag_i  (fwd_tag[k][op]),
            .byp_hit_i  (byp_hit[k][op]),
            .byp_data_i (bus.commit_data_i),
            .arr_v_i    (arr_v[k][op]),
            .arr_q_i    (arr_q[k][op]),
            .v_o        (sel_v[k][op]),
            .q_o        (sel_q[k][op])
         );
      end
   end

   // Array update: commit first, then renames in channel order so a rename
   // overrides the commit clear and the highest channel wins; flush last.
   always_comb begin
      rf_value_d = rf_value_q;
      rf_tag_d   = rf_tag_q;
      if (bus.commit_valid_i && bus.commit_rd_i != '0) begin
         rf_value_d[bus.commit_rd_i] = bus.commit_data_i;
         if (rf_tag_q[bus.commit_rd_i] == bus.commit_tag_i) begin
            rf_tag_d[bus.commit_rd_i] = TAG_W'(TAG_NONE);
         end
      end
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         if (accept[k] && disp_rd[k] != '0) begin
            rf_tag_d[disp_rd[k]] = disp_tag[k];
         end
      end
      if (bus.flush_i) begin
         for (int unsigned r = 0; r < REG_COUNT; r++) begin
            rf_tag_d[r] = TAG_W'(TAG_NONE);
         end
      end
   end

   // Result registers: cleared valid on flush, held on stall, loaded otherwise.
   always_comb begin
      out_valid_d = out_valid_q;
      out_v_d     = out_v_q;
      out_q_d     = out_q_q;
      out_rd_d    = out_rd_q;
      out_tag_d   = out_tag_q;
      if (bus.flush_i) begin
         out_valid_d = '0;
      end else if (bus.stall_i) begin
`ifdef RF_COMMIT_BYPASS_EN
         for (int unsigned k = 0; k < ISSUE_W; k++) begin
            for (int unsigned op = 0; op < 2; op++) begin
               if (bus.commit_valid_i && out_q_q[k][op] != TAG_W'(TAG_NONE) &&
                   out_q_q[k][op] == bus.commit_tag_i) begin
                  out_v_d[k][op] = bus.commit_data_i;
                  out_q_d[k][op] = TAG_W'(TAG_NONE);
               end
            end
         end
`endif
      end else begin
         for (int unsigned k = 0; k < ISSUE_W; k++) begin
            out_valid_d[k] = accept[k];
            if (accept[k]) begin
               out_v_d[k][0] = sel_v[k][0];
               out_q_d[k][0] = sel_q[k][0];
               out_v_d[k][1] = sel_v[k][1];
               out_q_d[k][1] = sel_q[k][1];
               out_rd_d[k]   = disp_rd[k];
               out_tag_d[k]  = disp_tag[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned r = 0; r < REG_COUNT; r++) begin
            rf_value_q[r] <= '0;
            rf_tag_q[r]   <= '0;
         end
         out_valid_q <= '0;
         for (int unsigned k = 0; k < ISSUE_W; k++) begin
            out_v_q[k][0] <= '0;
            out_v_q[k][1] <= '0;
            out_q_q[k][0] <= '0;
            out_q_q[k][1] <= '0;
            out_rd_q[k]   <= '0;
            out_tag_q[k]  <= '0;
         end
      end else begin
         rf_value_q  <= rf_value_d;
         rf_tag_q    <= rf_tag_d;
         out_valid_q <= out_valid_d;
         out_v_q     <= out_v_d;
         out_q_q     <= out_q_d;
         out_rd_q    <= out_rd_d;
         out_tag_q   <= out_tag_d;
      end
   end

   always_comb begin
      bus.out_valid_o = out_valid_q;
      bus.out_v1_o    = '0;
      bus.out_v2_o    = '0;
      bus.out_q1_o    = '0;
      bus.out_q2_o    = '0;
      bus.out_rd_o    = '0;
      bus.out_tag_o   = '0;
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         bus.out_v1_o[k*DATA_W +: DATA_W] = out_v_q[k][0];
         bus.out_v2_o[k*DATA_W +: DATA_W] = out_v_q[k][1];
         bus.out_q1_o[k*TAG_W +: TAG_W]   = out_q_q[k][0];
         bus.out_q2_o[k*TAG_W +: TAG_W]   = out_q_q[k][1];
         bus.out_rd_o[k*IDX_W +: IDX_W]   = out_rd_q[k];
         bus.out_tag_o[k*TAG_W +: TAG_W]  = out_tag_q[k];
      end
   end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed scenarios plus randomized traffic checked
// against a behavioural register-file model.
module tb_rename_regfile;
   import rf_pkg::*;

   localparam int RC = 32;
   localparam int DW = 32;
   localparam int TW = 32;
   localparam int IW = 2;
   localparam int XW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   rename_regfile_if #(.REG_COUNT(RC), .DATA_W(DW), .TAG_W(TW), .ISSUE_W(IW), .IDX_W(XW)) bus ();

   rename_regfile #(.REG_COUNT(RC), .DATA_W(DW), .TAG_W(TW), .ISSUE_W(IW), .IDX_W(XW)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] mval [RC];
   logic [TW-1:0] mtag [RC];
   bit            e_valid [IW];
   rf_operand_t   e_op [IW][2];
   logic [XW-1:0] e_rd [IW];
   logic [TW-1:0] e_tag [IW];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [XW-1:0] g_rd(int k);  return bus.disp_rd_i[k*XW +: XW];  endfunction
   function automatic logic [XW-1:0] g_rs1(int k); return bus.disp_rs1_i[k*XW +: XW]; endfunction
   function automatic logic [XW-1:0] g_rs2(int k); return bus.disp_rs2_i[k*XW +: XW]; endfunction
   function automatic logic [TW-1:0] g_tag(int k); return bus.disp_tag_i[k*TW +: TW]; endfunction
   function automatic logic [DW-1:0] o_v1(int k);  return bus.out_v1_o[k*DW +: DW];   endfunction
   function automatic logic [DW-1:0] o_v2(int k);  return bus.out_v2_o[k*DW +: DW];   endfunction
   function automatic logic [TW-1:0] o_q1(int k);  return bus.out_q1_o[k*TW +: TW];   endfunction
   function automatic logic [TW-1:0] o_q2(int k);  return bus.out_q2_o[k*TW +: TW];   endfunction

   task automatic clear_inputs();
      bus.flush_i        = 1'b0;
      bus.stall_i        = 1'b0;
      bus.commit_valid_i = 1'b0;
      bus.commit_rd_i    = '0;
      bus.commit_tag_i   = '0;
      bus.commit_data_i  = '0;
      bus.disp_valid_i   = '0;
      bus.disp_rd_i      = '0;
      bus.disp_rs1_i     = '0;
      bus.disp_rs2_i     = '0;
      bus.disp_tag_i     = '0;
   endtask

   task automatic set_ch(input int k, input bit v, input int rd, input int rs1, input int rs2,
                         input logic [TW-1:0] tg);
      bus.disp_valid_i[k]          = v;
      bus.disp_rd_i[k*XW +: XW]    = XW'(rd);
      bus.disp_rs1_i[k*XW +: XW]   = XW'(rs1);
      bus.disp_rs2_i[k*XW +: XW]   = XW'(rs2);
      bus.disp_tag_i[k*TW +: TW]   = tg;
   endtask

   task automatic commit(input int rd, input logic [TW-1:0] tg, input logic [DW-1:0] d);
      bus.commit_valid_i = 1'b1;
      bus.commit_rd_i    = XW'(rd);
      bus.commit_tag_i   = tg;
      bus.commit_data_i  = d;
   endtask

   task automatic model_reset();
      for (int r = 0; r < RC; r++) begin
         mval[r] = '0;
         mtag[r] = '0;
      end
      for (int k = 0; k < IW; k++) begin
         e_valid[k] = 1'b0;
         e_op[k][0] = '0;
         e_op[k][1] = '0;
         e_rd[k]    = '0;
         e_tag[k]   = '0;
      end
   endtask

   // Newest older producer in the bundle, else retiring commit, else register state.
   function automatic rf_operand_t read_op(int k, logic [XW-1:0] rs);
      rf_operand_t r;
      for (int j = k - 1; j >= 0; j--) begin
         if (bus.disp_valid_i[j] && g_rd(j) == rs && rs != 0) begin
            r.v = '0;
            r.q = g_tag(j);
            return r;
         end
      end
`ifdef RF_COMMIT_BYPASS_EN
      if (bus.commit_valid_i && bus.commit_rd_i == rs && rs != 0 && mtag[rs] == bus.commit_tag_i) begin
         r.v = bus.commit_data_i;
         r.q = TAG_NONE;
         return r;
      end
`endif
      r.v = mval[rs];
      r.q = mtag[rs];
      return r;
   endfunction

   task automatic model_step();
      bit rdy;
      rdy = !bus.stall_i && !bus.flush_i;
      if (bus.flush_i) begin
         for (int k = 0; k < IW; k++) e_valid[k] = 1'b0;
      end else if (bus.stall_i) begin
`ifdef RF_COMMIT_BYPASS_EN
         for (int k = 0; k < IW; k++)
            for (int op = 0; op < 2; op++)
               if (bus.commit_valid_i && e_op[k][op].q != 0 && e_op[k][op].q == bus.commit_tag_i) begin
                  e_op[k][op].v = bus.commit_data_i;
                  e_op[k][op].q = TAG_NONE;
               end
`endif
      end else begin
         for (int k = 0; k < IW; k++) begin
            e_valid[k] = bus.disp_valid_i[k];
            if (bus.disp_valid_i[k]) begin
               e_op[k][0] = read_op(k, g_rs1(k));
               e_op[k][1] = read_op(k, g_rs2(k));
               e_rd[k]    = g_rd(k);
               e_tag[k]   = g_tag(k);
            end
         end
      end
      if (bus.commit_valid_i && bus.commit_rd_i != 0) begin
         mval[bus.commit_rd_i] = bus.commit_data_i;
         if (mtag[bus.commit_rd_i] == bus.commit_tag_i) mtag[bus.commit_rd_i] = '0;
      end
      if (rdy)
         for (int k = 0; k < IW; k++)
            if (bus.disp_valid_i[k] && g_rd(k) != 0) mtag[g_rd(k)] = g_tag(k);
      if (bus.flush_i)
         for (int r = 0; r < RC; r++) mtag[r] = '0;
   endtask

   task automatic compare_outputs();
      logic [IW-1:0] ev;
      for (int k = 0; k < IW; k++) ev[k] = e_valid[k];
      chk("out_valid", bus.out_valid_o, ev);
      for (int k = 0; k < IW; k++) begin
         if (e_valid[k]) begin
            chk($sformatf("v1[%0d]", k), o_v1(k), e_op[k][0].v);
            chk($sformatf("q1[%0d]", k), o_q1(k), e_op[k][0].q);
            chk($sformatf("v2[%0d]", k), o_v2(k), e_op[k][1].v);
            chk($sformatf("q2[%0d]", k), o_q2(k), e_op[k][1].q);
            chk($sformatf("rd[%0d]", k), bus.out_rd_o[k*XW +: XW], e_rd[k]);
            chk($sformatf("tag[%0d]", k), bus.out_tag_o[k*TW +: TW], e_tag[k]);
         end
      end
   endtask

   // Inputs are driven just after a falling edge; results sampled 1ns after the rising edge.
   task automatic step();
      #1;
      chk("disp_ready", bus.disp_ready_o, !(bus.stall_i || bus.flush_i));
      model_step();
      @(posedge clk);
      #1;
      compare_outputs();
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_valid"}, bus.out_valid_o, 0);
      chk({name, "_v1"}, bus.out_v1_o, 0);
      chk({name, "_v2"}, bus.out_v2_o, 0);
      chk({name, "_q1"}, bus.out_q1_o, 0);
      chk({name, "_q2"}, bus.out_q2_o, 0);
      chk({name, "_rd"}, bus.out_rd_o, 0);
      chk({name, "_tag"}, bus.out_tag_o, 0);
   endtask

   initial begin
      int rd;
      logic [TW-1:0] tg;
      clear_inputs();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // reset then read
      set_ch(0, 1, 0, 5, 0, 32'h11);
      step();
      chk("t1_valid", bus.out_valid_o, 2'b01);
      chk("t1_v1", o_v1(0), 0);
      chk("t1_q1", o_q1(0), 0);
      chk("t1_q2", o_q2(0), 0);

      // intra-bundle dependency
      clear_inputs();
      set_ch(0, 1, 3, 0, 0, 32'h100);
      set_ch(1, 1, 0, 3, 0, 32'h101);
      step();
      chk("t2_q1_ch1", o_q1(1), 32'h100);
      chk("t2_v1_ch1", o_v1(1), 0);
      clear_inputs();
      set_ch(0, 1, 0, 3, 0, 32'h102);
      step();
      chk("t2_tag3", o_q1(0), 32'h100);

      // stale commit keeps the younger rename
      clear_inputs();
      set_ch(0, 1, 7, 0, 0, 32'h20);
      step();
      clear_inputs();
      commit(7, 32'h10, 32'hAB);
      step();
      clear_inputs();
      set_ch(0, 1, 0, 7, 0, 32'h21);
      step();
      chk("t3_v7", o_v1(0), 32'hAB);
      chk("t3_tag7", o_q1(0), 32'h20);

      // same-cycle commit vs read
      clear_inputs();
      set_ch(0, 1, 4, 0, 0, 32'h30);
      step();
      clear_inputs();
      commit(4, 32'h30, 32'h55);
      set_ch(0, 1, 0, 0, 4, 32'h31);
      step();
`ifdef RF_COMMIT_BYPASS_EN
      chk("t4_v2", o_v2(0), 32'h55);
      chk("t4_q2", o_q2(0), 0);
`else
      chk("t4_v2", o_v2(0), 0);
      chk("t4_q2", o_q2(0), 32'h30);
`endif

      // flush
      clear_inputs();
      set_ch(0, 1, 1, 0, 0, 32'h41);
      set_ch(1, 1, 2, 0, 0, 32'h42);
      step();
      clear_inputs();
      set_ch(0, 1, 3, 0, 0, 32'h43);
      step();
      clear_inputs();
      bus.flush_i = 1'b1;
      commit(2, 32'h99, 32'd9);
      set_ch(0, 1, 5, 0, 0, 32'h45);
      step();
      chk("t5_valid", bus.out_valid_o, 2'b00);
      clear_inputs();
      set_ch(0, 1, 0, 2, 1, 32'h46);
      set_ch(1, 1, 0, 3, 5, 32'h47);
      step();
      chk("t5_v2", o_v1(0), 32'd9);
      chk("t5_q2", o_q1(0), 0);
      chk("t5_q1", o_q2(0), 0);
      chk("t5_q3", o_q1(1), 0);
      chk("t5_q5", o_q2(1), 0);

      // stall hold
      clear_inputs();
      set_ch(0, 1, 6, 2, 0, 32'h50);
      step();
      clear_inputs();
      bus.stall_i = 1'b1;
      set_ch(0, 1, 5, 6, 0, 32'h77);
      commit(2, 32'h0, 32'h12);
      repeat (3) begin
         step();
         chk("t6_valid", bus.out_valid_o, 2'b01);
         chk("t6_v1", o_v1(0), 32'd9);
      end
      clear_inputs();
      set_ch(0, 1, 0, 2, 5, 32'h51);
      set_ch(1, 1, 0, 6, 0, 32'h52);
      step();
      chk("t6_v2_new", o_v1(0), 32'h12);
      chk("t6_q5", o_q2(0), 0);
      chk("t6_q6", o_q1(1), 32'h50);

      // asynchronous reset mid-operation
      clear_inputs();
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      set_ch(0, 1, 0, 6, 0, 32'h60);
      step();
      chk("midrst_first", bus.out_valid_o, 2'b01);
      chk("midrst_q6", o_q1(0), 0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         clear_inputs();
         bus.stall_i = ($urandom_range(0, 6) == 0);
         bus.flush_i = ($urandom_range(0, 24) == 0);
         for (int k = 0; k < IW; k++)
            set_ch(k, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), TW'($urandom_range(1, 255)));
         if ($urandom_range(0, 1) == 1) begin
            rd = $urandom_range(0, 7);
            tg = ($urandom_range(0, 1) == 1) ? mtag[rd] : TW'($urandom_range(1, 255));
            commit(rd, tg, $urandom);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with rename tags for the out-of-order core. It sits between the decoder and the ROB. Per cycle it does three things: dispatches up to `ISSUE_W` instructions, records each destination's producing tag, and returns registered operand value/tag pairs to the ROB. It also retires one committed result per cycle and clears every tag on an exception flush.

## Interface
- `REG_COUNT`, 32, number of architectural registers; x0 hardwired zero.
- `DATA_W`, 32, register data width.
- `TAG_W`, 32, rename tag width. Tag 0 means "value ready"; dispatch tags are always nonzero.
- `ISSUE_W`, 2, dispatch channels per cycle. Channel k is older than channel k+1.
- `IDX_W`, $clog2(REG_COUNT), register index width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  exception flush from the ROB.
- `stall_i`  in  1  ROB cannot accept; hold outputs.
- `commit_valid_i`  in  1  a commit is present.
- `commit_rd_i`  in  IDX_W  commit destination register.
- `commit_tag_i`  in  TAG_W  tag of the committing instruction.
- `commit_data_i`  in  DATA_W  commit result value.
- `disp_valid_i`  in  ISSUE_W  per-channel dispatch valid.
- `disp_rd_i`, `disp_rs1_i`, `disp_rs2_i`  in  ISSUE_W*IDX_W  packed register indices; channel k occupies slice k.
- `disp_tag_i`  in  ISSUE_W*TAG_W  packed tag of each dispatched instruction.
- `disp_ready_o`  out  1  equals !stall_i && !flush_i.
- `out_valid_o`  out  ISSUE_W  per-channel result valid.
- `out_v1_o`, `out_v2_o`  out  ISSUE_W*DATA_W  operand values.
- `out_q1_o`, `out_q2_o`  out  ISSUE_W*TAG_W  operand tags; 0 means the value is valid.
- `out_rd_o`  out  ISSUE_W*IDX_W  registered destination index.
- `out_tag_o`  out  ISSUE_W*TAG_W  registered instruction tag.

## Operation
- Storage: `value[REG_COUNT]` and `tag[REG_COUNT]`. Register 0 always reads value 0 and tag 0, and writes to it are discarded.
- Dispatch is accepted when `disp_valid_i[k] && disp_ready_o`.
- Commit:
  - `value[commit_rd]` ← `commit_data_i`.
  - `tag[commit_rd]` ← 0 only if it equals `commit_tag_i`; a younger rename is kept.
- Dispatch rename: `tag[disp_rd[k]]` ← `disp_tag[k]`.
  - Rename wins over a same-cycle commit clear of the same register.
  - Two channels with the same rd: the highest k wins.
- Operand read for channel k, in priority order:
  - If an older accepted channel j<k in the same bundle writes this rs, take the largest such j: q ← `disp_tag[j]`, v ← 0.
  - Otherwise, if `RF_COMMIT_BYPASS_EN` is defined and the commit matches this rs and the current tag, v ← commit data and q ← 0.
  - Otherwise v and q come from the array.
- Flush:
  - All tags and all `out_valid_o` bits are cleared.
  - A same-cycle commit value is still written.
  - Dispatch is ignored.
- Stall:
  - Outputs hold.
  - No dispatch tag updates occur.
  - Commits are still processed.

## Timing
- Latency: outputs are registered exactly 1 cycle after dispatch acceptance.
- The `out_valid_o` bit for channel k is 1 in the cycle after channel k is accepted. It is 0 after a non-stalled cycle with no dispatch on that channel.
- Commit becomes visible to an array read in the next cycle, or in the same cycle with bypass.
- Reset values:
  - All outputs 0.
  - `value`/`tag` arrays 0.
  - `disp_ready_o` follows its inputs combinationally.
- Reset asserted mid-operation clears state immediately and asynchronously. The first dispatch is accepted on the first edge after deassertion.

## Configuration
- `RF_COMMIT_BYPASS_EN` defined:
  - Same-cycle commit forwarding into dispatch reads.
  - While stalled, held outputs snoop commits: a held q equal to `commit_tag_i` is replaced by v = data, q = 0.
- Undefined: reads return pre-commit array contents, held outputs are not updated, and the ROB must snoop commits itself.

## Structure
- Shared package `rf_pkg`:
  - `TAG_NONE` = 0.
  - Default widths.
  - Typedef `rf_operand_t` {v, q}.
- Sub-module `rf_operand_sel`: per-operand priority mux over intra-bundle, bypass and array sources. It is instantiated 2*ISSUE_W times.

## Test plan
- Reset then read: reset, dispatch rs1=5, rs2=0 on ch0 → v1=0, q1=0, v2=0, q2=0, out_valid=01.
- Intra-bundle dependency: ch0 rd=3 tag=0x100; ch1 rs1=3 → ch1 q1=0x100; `tag[3]`=0x100 afterwards.
- Stale commit: `tag[7]`=0x20, commit rd=7 tag=0x10 data=0xAB → `value[7]`=0xAB and `tag[7]` stays 0x20.
- Commit bypass (macro on): commit rd=4 tag=0x30 data=0x55 in the same cycle as ch0 rs2=4 with `tag[4]`=0x30 → v2=0x55, q2=0. With the macro off: q2=0x30.
- Flush: tags set on x1–x3, flush_i=1 with commit rd=2 data=9 → all tags 0, `value[2]`=9, out_valid=00, disp_ready_o=0.
- Stall hold: stall_i=1 for 3 cycles with dispatch driven → outputs unchanged, tags unchanged, commits still applied.
